// File: rtl/psum_pkg.sv
// psum_pkg: shared state encoding and lane arithmetic for the psum write-back path.
package psum_pkg;

    localparam int unsigned PSUM_BW_DEF = 16;
    localparam int unsigned COL_DEF     = 8;
    // Widest lane the shared lane function can handle
    localparam int unsigned LANE_MAX_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ADD  = 2'd2,
        ST_WR   = 2'd3
    } psum_state_e;

    // One bit of headroom above the widest lane so a lane sum never overflows
    typedef logic signed [LANE_MAX_W:0] lane_wide_t;

    // Bound a widened lane sum to a bw-bit signed lane, then optionally rectify.
    // sat=1 clamps to the signed range, sat=0 keeps the low bw bits (wrap).
    function automatic lane_wide_t lane_sat_relu(
        input lane_wide_t  sum,
        input int unsigned bw,
        input logic        sat,
        input logic        relu
    );
        lane_wide_t  one;
        lane_wide_t  hi;
        lane_wide_t  lo;
        lane_wide_t  res;
        int unsigned sh;
        one = lane_wide_t'({{LANE_MAX_W{1'b0}}, 1'b1});
        hi  = (one <<< (bw - 32'd1)) - one;
        lo  = -hi - one;
        sh  = LANE_MAX_W + 32'd1 - bw;
        if (sat) begin
            if (sum > hi) begin
                res = hi;
            end else if (sum < lo) begin
                res = lo;
            end else begin
                res = sum;
            end
        end else begin
            // Shift up then arithmetic shift down: keeps low bw bits, sign-extended
            res = (sum <<< sh) >>> sh;
        end
        return (relu && res[LANE_MAX_W]) ? {(LANE_MAX_W + 1){1'b0}} : res;
    endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// psum_lane_alu: combinational add / saturate-or-wrap / ReLU for one psum lane.
module psum_lane_alu
    import psum_pkg::*;
#(
    parameter int unsigned PSUM_BW = PSUM_BW_DEF,
    parameter int unsigned SAT     = 1
) (
    input  logic signed [PSUM_BW-1:0] old_val,
    input  logic signed [PSUM_BW-1:0] new_val,
    input  logic                      acc,
    input  logic                      relu,
    output logic signed [PSUM_BW-1:0] result
);

    lane_wide_t sum_s;
    lane_wide_t res_s;
    logic       lane_unused_s;

    // Widen both operands, add when accumulating, then bound and rectify
    always_comb begin
        if (acc) begin
            sum_s = lane_wide_t'(old_val) + lane_wide_t'(new_val);
        end else begin
            sum_s = lane_wide_t'(new_val);
        end
        res_s = lane_sat_relu(sum_s, PSUM_BW, (SAT != 32'd0), relu);
    end

    assign result        = res_s[PSUM_BW-1:0];
    // Upper bits are only sign extension once the result is bounded
    assign lane_unused_s = ^res_s[LANE_MAX_W:PSUM_BW];

endmodule

// File: rtl/psum_accum_wb.sv
// psum_accum_wb: writes OFIFO rows into the single-port psum SRAM, either as a
// plain overwrite (1 row/cycle) or as a read-modify-write accumulate (RD, ADD, WR).
module psum_accum_wb
    import psum_pkg::*;
#(
    parameter int unsigned COL     = COL_DEF,
    parameter int unsigned PSUM_BW = PSUM_BW_DEF,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned SAT     = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COL*PSUM_BW-1:0] in_data,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic                   in_acc,
    input  logic                   in_relu,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [ADDR_W-1:0]      mem_a,
    output logic [COL*PSUM_BW-1:0] mem_d,
    input  logic [COL*PSUM_BW-1:0] mem_q,
    output logic                   busy,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int unsigned ROW_W = COL * PSUM_BW;

    psum_state_e       state_r;
    psum_state_e       state_nxt_s;
    logic              accept_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ROW_W-1:0]  data_r;
    logic              relu_r;
    logic [ADDR_W-1:0] addr_src_s;
    logic              alu_acc_s;
    logic              alu_relu_s;
    logic [ROW_W-1:0]  alu_new_s;
    logic [ROW_W-1:0]  alu_res_s;
    logic              in_ready_r;
    logic              busy_r;
    logic              mem_cen_r;
    logic              mem_wen_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic [ROW_W-1:0]  wbuf_r;
    logic [CNT_W-1:0]  wr_count_r;
    logic              in_ready_nxt_s;
    logic              busy_nxt_s;
    logic              mem_cen_nxt_s;
    logic              mem_wen_nxt_s;
    logic [ADDR_W-1:0] mem_a_nxt_s;
    logic [ROW_W-1:0]  wbuf_nxt_s;

    assign accept_s   = in_valid && in_ready_r;
    // A fresh accept targets the incoming address; otherwise the latched one
    assign addr_src_s = accept_s ? in_addr : addr_r;

    // ALU operands: RMW merge of SRAM data in ADD, pass-through with ReLU otherwise
    always_comb begin
        if (state_r == ST_ADD) begin
            alu_acc_s  = 1'b1;
            alu_relu_s = relu_r;
            alu_new_s  = data_r;
        end else begin
            alu_acc_s  = 1'b0;
            alu_relu_s = in_relu;
            alu_new_s  = in_data;
        end
    end

    for (genvar g = 0; g < int'(COL); g++) begin : g_lane
        psum_lane_alu #(
            .PSUM_BW (PSUM_BW),
            .SAT     (SAT)
        ) u_lane_alu (
            .old_val (mem_q[g*PSUM_BW +: PSUM_BW]),
            .new_val (alu_new_s[g*PSUM_BW +: PSUM_BW]),
            .acc     (alu_acc_s),
            .relu    (alu_relu_s),
            .result  (alu_res_s[g*PSUM_BW +: PSUM_BW])
        );
    end

    // FSM state register; reset drops any pending row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: RD and ADD always advance, IDLE and WR look at the handshake
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_WR: begin
                if (accept_s) begin
                    state_nxt_s = in_acc ? ST_RD : ST_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD:   state_nxt_s = ST_ADD;
            ST_ADD:  state_nxt_s = ST_WR;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the upcoming state so every pin leaves a flop
    always_comb begin
        in_ready_nxt_s = 1'b1;
        busy_nxt_s     = 1'b0;
        mem_cen_nxt_s  = 1'b1;
        mem_wen_nxt_s  = 1'b1;
        mem_a_nxt_s    = {ADDR_W{1'b0}};
        wbuf_nxt_s     = {ROW_W{1'b0}};
        case (state_nxt_s)
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
            end
            ST_RD: begin
                in_ready_nxt_s = 1'b0;
                busy_nxt_s     = 1'b1;
                mem_cen_nxt_s  = 1'b0;
                mem_a_nxt_s    = addr_src_s;
            end
            ST_ADD: begin
                in_ready_nxt_s = 1'b0;
                busy_nxt_s     = 1'b1;
            end
            ST_WR: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b1;
                mem_cen_nxt_s  = 1'b0;
                mem_wen_nxt_s  = 1'b0;
                mem_a_nxt_s    = addr_src_s;
                wbuf_nxt_s     = alu_res_s;
            end
            default: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
            end
        endcase
    end

    // Row latch: address, data and ReLU flag captured on every accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {ROW_W{1'b0}};
            relu_r <= 1'b0;
        end else if (accept_s) begin
            addr_r <= in_addr;
            data_r <= in_data;
            relu_r <= in_relu;
        end else begin
            addr_r <= addr_r;
            data_r <= data_r;
            relu_r <= relu_r;
        end
    end

    // Output registers: handshake, busy and SRAM pins; the write buffer doubles as mem_d
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            mem_cen_r  <= 1'b1;
            mem_wen_r  <= 1'b1;
            mem_a_r    <= {ADDR_W{1'b0}};
            wbuf_r     <= {ROW_W{1'b0}};
        end else begin
            in_ready_r <= in_ready_nxt_s;
            busy_r     <= busy_nxt_s;
            mem_cen_r  <= mem_cen_nxt_s;
            mem_wen_r  <= mem_wen_nxt_s;
            mem_a_r    <= mem_a_nxt_s;
            wbuf_r     <= wbuf_nxt_s;
        end
    end

    // Write counter: one tick per completed WR cycle, wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_WR) begin
            wr_count_r <= wr_count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    assign in_ready = in_ready_r;
    assign busy     = busy_r;
    assign mem_cen  = mem_cen_r;
    assign mem_wen  = mem_wen_r;
    assign mem_a    = mem_a_r;
    assign mem_d    = wbuf_r;
    assign wr_count = wr_count_r;

endmodule

// File: tb/tb_psum_accum_wb.sv
// tb_psum_accum_wb: two instances (saturating / wrapping with a 3-bit counter)
// share one stimulus stream; each owns an SRAM model. A reference model computed
// lane by lane with integer arithmetic predicts every write and the final memory.
module tb_psum_accum_wb;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;
    localparam int RW  = COL * BW;
    localparam int CW1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_acc;
    logic          in_relu;
    logic [RW-1:0] in_data;
    logic [AW-1:0] in_addr;

    logic          rdy0, cen0, wen0, busy0;
    logic [AW-1:0] a0;
    logic [RW-1:0] d0, q0;
    logic [15:0]   cnt0;
    logic          rdy1, cen1, wen1, busy1;
    logic [AW-1:0] a1;
    logic [RW-1:0] d1, q1;
    logic [CW1-1:0] cnt1;

    psum_accum_wb #(.COL(COL), .PSUM_BW(BW), .ADDR_W(AW), .SAT(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_addr(in_addr), .in_acc(in_acc), .in_relu(in_relu),
        .mem_cen(cen0), .mem_wen(wen0), .mem_a(a0), .mem_d(d0), .mem_q(q0),
        .busy(busy0), .wr_count(cnt0)
    );

    psum_accum_wb #(.COL(COL), .PSUM_BW(BW), .ADDR_W(AW), .SAT(0), .CNT_W(CW1)) u_dut1 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_addr(in_addr), .in_acc(in_acc), .in_relu(in_relu),
        .mem_cen(cen1), .mem_wen(wen1), .mem_a(a1), .mem_d(d1), .mem_q(q1),
        .busy(busy1), .wr_count(cnt1)
    );

    logic [RW-1:0] sram0 [0:(1<<AW)-1];
    logic [RW-1:0] sram1 [0:(1<<AW)-1];

    // Single-port SRAM models: write or registered read on the rising edge
    always @(posedge clk) begin
        if (!cen0) begin
            if (!wen0) sram0[a0] <= d0;
            else       q0 <= sram0[a0];
        end
        if (!cen1) begin
            if (!wen1) sram1[a1] <= d1;
            else       q1 <= sram1[a1];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int exp_writes = 0;
    int stall_cycles = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] d0;
        logic [RW-1:0] d1;
    } wr_t;
    wr_t exp_q[$];

    logic [RW-1:0] ref0 [0:(1<<AW)-1];
    logic [RW-1:0] ref1 [0:(1<<AW)-1];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] fill(input int v);
        logic [RW-1:0] r;
        logic [31:0]   t;
        t = v;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = t[BW-1:0];
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) begin
            logic [31:0] t;
            case ($urandom_range(0, 2))
                0:       t = $urandom;
                1:       t = 32'd32000 + $urandom_range(0, 767);
                default: t = 32'd0 - 32'd32000 - $urandom_range(0, 768);
            endcase
            r[i*BW +: BW] = t[BW-1:0];
        end
        return r;
    endfunction

    // Reference lane rule: sum in plain integers, clamp or wrap, then ReLU
    function automatic logic [RW-1:0] ref_row(input logic [RW-1:0] old_row, input logic [RW-1:0] new_row,
                                              input bit acc, input bit relu, input bit sat);
        logic [RW-1:0] r;
        for (int i = 0; i < COL; i++) begin
            int o, n, s;
            logic [31:0] sv;
            o = $signed(old_row[i*BW +: BW]);
            n = $signed(new_row[i*BW +: BW]);
            s = acc ? o + n : n;
            if (sat) begin
                if (s > 32767) s = 32767;
                if (s < -32768) s = -32768;
            end else begin
                s = ((s + 32768) % 65536 + 65536) % 65536 - 32768;
            end
            if (relu && s < 0) s = 0;
            sv = s;
            r[i*BW +: BW] = sv[BW-1:0];
        end
        return r;
    endfunction

    task automatic model_accept(input logic [AW-1:0] addr, input logic [RW-1:0] data, input bit acc, input bit relu);
        wr_t w;
        w.addr = addr;
        w.d0   = ref_row(ref0[addr], data, acc, relu, 1'b1);
        w.d1   = ref_row(ref1[addr], data, acc, relu, 1'b0);
        ref0[addr] = w.d0;
        ref1[addr] = w.d1;
        exp_q.push_back(w);
        exp_writes++;
    endtask

    // Write monitor: each SRAM write must be the next predicted one
    always @(negedge clk) begin
        if ((!cen0 && !wen0) || (!cen1 && !wen1)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %0d written, no write pending", a0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr_sat", a0, w.addr);
                chk("wr_data_sat", d0, w.d0);
                chk("wr_addr_wrap", a1, w.addr);
                chk("wr_data_wrap", d1, w.d1);
                chk("wr_pins_wrap", {cen1, wen1}, 2'b00);
            end
        end
    end

    // Offer one row and hold it until accepted (bounded wait)
    task automatic send(input logic [AW-1:0] addr, input logic [RW-1:0] data, input bit acc, input bit relu);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_addr  = addr;
        in_data  = data;
        in_acc   = acc;
        in_relu  = relu;
        @(negedge clk);
        while (!rdy0 && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        stall_cycles += waited;
        if (!rdy0) begin
            chk("accept_timeout", rdy0, 1'b1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(addr, data, acc, relu);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            valid;
        bit            acc;
        logic [AW-1:0] addr;
        int            lane;
        bit            rdy;
        bit            busy;
        bit            cen;
        bit            wen;
        logic [AW-1:0] a;
        int            cnt_delta;
    } vec_t;
    vec_t tv[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;

        // Accumulate timing plus two back-to-back overwrites of the same address
        tv[0] = '{1'b1, 1'b1, 11'd7, 23, 1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 0};
        tv[1] = '{1'b0, 1'b0, 11'd0, 0,  1'b0, 1'b1, 1'b0, 1'b1, 11'd7, 0};
        tv[2] = '{1'b0, 1'b0, 11'd0, 0,  1'b0, 1'b1, 1'b1, 1'b1, 11'd0, 0};
        tv[3] = '{1'b1, 1'b0, 11'd3, 5,  1'b1, 1'b1, 1'b0, 1'b0, 11'd7, 0};
        tv[4] = '{1'b1, 1'b0, 11'd3, 6,  1'b1, 1'b1, 1'b0, 1'b0, 11'd3, 1};
        tv[5] = '{1'b0, 1'b0, 11'd0, 0,  1'b1, 1'b1, 1'b0, 1'b0, 11'd3, 2};
        tv[6] = '{1'b0, 1'b0, 11'd0, 0,  1'b1, 1'b0, 1'b1, 1'b1, 11'd0, 3};

        rst_n = 1'b0;
        in_valid = 1'b0; in_acc = 1'b0; in_relu = 1'b0;
        in_data = {RW{1'b0}}; in_addr = {AW{1'b0}};
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", rdy0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_cen_wen", {cen0, wen0}, 2'b11);
        chk("rst_mem_a", a0, {AW{1'b0}});
        chk("rst_mem_d", d0, {RW{1'b0}});
        chk("rst_wr_count", cnt0, 16'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Overwrite stream: four rows, one per cycle
        stall_cycles = 0;
        for (int i = 0; i < 4; i++) send(AW'(i), fill(5), 1'b0, 1'b0);
        @(negedge clk);
        chk("ow_stall", stall_cycles, 0);
        chk("ow_count_mid", cnt0, 16'd3);
        chk("ow_last_addr", a0, 11'd3);
        @(negedge clk);
        chk("ow_count_end", cnt0, 16'd4);
        chk("ow_idle_cen", cen0, 1'b1);
        idle(1);

        // Accumulate timing table
        send(11'd7, fill(100), 1'b0, 1'b0);
        idle(2);
        base = exp_writes;
        for (int i = 0; i < 7; i++) begin
            in_valid = tv[i].valid;
            in_acc   = tv[i].acc;
            in_addr  = tv[i].addr;
            in_data  = fill(tv[i].lane);
            in_relu  = 1'b0;
            @(negedge clk);
            chk($sformatf("tv%0d_in_ready", i), rdy0, tv[i].rdy);
            chk($sformatf("tv%0d_busy", i), busy0, tv[i].busy);
            chk($sformatf("tv%0d_cen_wen", i), {cen0, wen0}, {tv[i].cen, tv[i].wen});
            chk($sformatf("tv%0d_mem_a", i), a0, tv[i].a);
            chk($sformatf("tv%0d_wr_count", i), cnt0, RW'(base + tv[i].cnt_delta));
            @(posedge clk);
            if (tv[i].valid && rdy0) model_accept(tv[i].addr, fill(tv[i].lane), tv[i].acc, 1'b0);
            #1;
        end
        in_valid = 1'b0;
        idle(2);
        chk("acc_7_is_123", sram0[7], fill(123));
        chk("last_overwrite_wins", sram0[3], fill(6));

        // Saturation versus wrap
        send(11'd20, fill(32000), 1'b0, 1'b0);
        send(11'd21, fill(-32000), 1'b0, 1'b0);
        send(11'd20, fill(1000), 1'b1, 1'b0);
        send(11'd21, fill(-1000), 1'b1, 1'b0);
        idle(4);
        chk("sat_pos", sram0[20], fill(32767));
        chk("wrap_pos", sram1[20], fill(-32536));
        chk("sat_neg", sram0[21], fill(-32768));
        chk("wrap_neg", sram1[21], fill(32536));

        // ReLU on accumulate and on overwrite
        send(11'd30, fill(-10), 1'b0, 1'b0);
        send(11'd31, fill(-10), 1'b0, 1'b0);
        send(11'd30, fill(3), 1'b1, 1'b1);
        send(11'd31, fill(3), 1'b1, 1'b0);
        send(11'd32, fill(-5), 1'b0, 1'b1);
        idle(4);
        chk("relu_acc_on", sram0[30], fill(0));
        chk("relu_acc_off", sram0[31], fill(-7));
        chk("relu_overwrite", sram0[32], fill(0));

        // Read-after-write to the same address, back to back
        send(11'd9, fill(50), 1'b0, 1'b0);
        send(11'd9, fill(1), 1'b1, 1'b0);
        @(negedge clk);
        chk("raw_rd_pins", {cen0, wen0, a0}, {2'b01, 11'd9});
        @(negedge clk);
        @(negedge clk);
        chk("raw_wr_pins", {cen0, wen0, a0}, {2'b00, 11'd9});
        chk("raw_wr_data", d0, fill(51));
        idle(2);
        chk("raw_mem", sram0[9], fill(51));

        // Reset in the middle of an accumulate
        in_valid = 1'b1; in_acc = 1'b1; in_relu = 1'b0;
        in_addr = 11'd9; in_data = fill(7);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rmw_in_add", {rdy0, busy0, cen0}, 3'b011);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cen", cen0, 1'b1);
        chk("rst_mid_in_ready", rdy0, 1'b1);
        chk("rst_mid_busy", busy0, 1'b0);
        chk("rst_mid_count", cnt0, 16'd0);
        chk("rst_mid_count_wrap", cnt1, 3'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_writes = 0;
        idle(5);
        chk("rst_mid_no_write", sram0[9], fill(51));
        chk("rst_mid_count_after", cnt0, 16'd0);
        chk("rst_mid_ready_after", rdy0, 1'b1);

        // Randomised traffic over a small address window (forces RAW hazards)
        for (int i = 0; i < 16; i++) send(AW'(i), rnd_row(), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            send(AW'($urandom_range(0, 15)), rnd_row(), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(6);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rand_mem_sat_%0d", i), sram0[i], ref0[i]);
            chk($sformatf("rand_mem_wrap_%0d", i), sram1[i], ref1[i]);
        end
        chk("rand_wr_count", cnt0, RW'(exp_writes % 65536));
        chk("rand_wr_count_wrap", cnt1, RW'(exp_writes % 8));
        chk("exp_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psum_accum_wb.md
# psum_accum_wb

Parametrised psum write-back engine that takes OFIFO rows and writes them into the single-port psum SRAM. It is the successor to the fixed 8-column, plain-write psum path, and adds three things that path lacks:
- per-row accumulate-on-write (read-modify-write);
- signed saturation;
- optional ReLU on write.

It sits between the corelet OFIFO and the psum SRAM, and owns the SRAM control pins (CEN/WEN/A/D) whenever it is busy.

## Interface
Parameters:
- COL, 8, number of output columns (lanes) per row
- PSUM_BW, 16, signed width of each lane
- ADDR_W, 11, psum SRAM address width
- SAT, 1, 1: saturate lane sums to the signed PSUM_BW range; 0: wrap modulo 2^PSUM_BW
- CNT_W, 16, width of the write counter

Ports:
- clk  in  1  single clock; everything is rising-edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  an input row is offered
- in_ready  out  1  block can accept a row this cycle
- in_data  in  COL*PSUM_BW  row data; lane i is bits [i*PSUM_BW +: PSUM_BW], signed
- in_addr  in  ADDR_W  target psum address
- in_acc  in  1  1: new = old + in_data; 0: new = in_data (overwrite)
- in_relu  in  1  clamp negative lanes to 0 before the write
- mem_cen  out  1  SRAM chip enable, active low
- mem_wen  out  1  SRAM write enable, active low
- mem_a  out  ADDR_W  SRAM address
- mem_d  out  COL*PSUM_BW  SRAM write data
- mem_q  in  COL*PSUM_BW  SRAM read data, valid one cycle after a read edge
- busy  out  1  high whenever the FSM is not in IDLE
- wr_count  out  CNT_W  number of SRAM writes completed; wraps

## Operation
A row is accepted on any cycle where in_valid and in_ready are both high. When a row is accepted, addr, data, acc and relu are latched.

FSM states:
- IDLE
  - in_ready = 1.
  - Accept with acc=1 -> RD.
  - Accept with acc=0 -> WR (write data = in_data after ReLU).
- RD
  - Drive mem_cen=0, mem_wen=1, mem_a=latched addr.
  - in_ready = 0. Always -> ADD.
- ADD
  - Sample mem_q. Compute per-lane sum = old + new at PSUM_BW+1 bits, saturate (SAT=1) or truncate (SAT=0), then apply ReLU if latched.
  - Register the result into the write buffer.
  - in_ready = 0. Always -> WR.
- WR
  - Drive mem_cen=0, mem_wen=0, mem_a=addr, mem_d=write buffer. wr_count increments at the end of the cycle.
  - in_ready = 1, so a back-to-back accept is allowed.
  - Accept with acc=0 -> WR. Accept with acc=1 -> RD. No accept -> IDLE.

Arithmetic:
- Saturation bounds: +2^(PSUM_BW-1)-1 and -2^(PSUM_BW-1).
- ReLU is applied after saturation.
- Lanes are independent; there is no cross-lane carry.

Hazards:
- A WR always completes before any later RD of the same address, so a read-after-write to the same address returns the new value with no forwarding.
- Two overwrites to the same address on consecutive cycles: the last one wins.

When not in RD or WR, the SRAM pins idle at: mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.

Reset (asynchronous, any state, including mid-RMW):
- FSM -> IDLE; the pending row is dropped.
- wr_count=0; write buffer cleared.
- Outputs: in_ready=1, busy=0, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0.

## Timing
- All outputs are registered or decoded from registered state; there is no path from in_* to mem_* within the same cycle.
- Overwrite: a row accepted at edge t is written at edge t+1. Sustained rate is 1 row/cycle.
- Accumulate: accept at t; RD cycle t..t+1; ADD t+1..t+2; write edge t+3. Sustained rate is 1 row per 3 cycles.
- in_ready drops for exactly the RD and ADD cycles.
- busy is high for every cycle in RD, ADD or WR.
- wr_count at CNT_W all-ones wraps to 0.
- An input held with in_ready low must stay stable; the block does not need to check this.

## Structure
- Shared package (psum_pkg): PSUM_BW and COL defaults, a state enum {IDLE, RD, ADD, WR}, and a lane saturate/ReLU function reused by the SFP.
- One sub-module: psum_lane_alu, the combinational add/saturate/ReLU for a single lane, instantiated COL times with a generate loop.
- The FSM and the input/write registers live in the top module.

## Test plan
- Overwrite stream: 4 back-to-back rows at addr 0..3, all lanes = 5 -> 4 consecutive write cycles, wr_count=4, in_ready never low.
- Accumulate: mem[7] lanes = 100; send addr 7, acc=1, data 23 -> RD at cycle 1, write of 123 at cycle 3, in_ready low for 2 cycles.
- Saturation: PSUM_BW=16, old=32000, add 1000, SAT=1 -> 32767. Same with SAT=0 -> -32536. old=-32000, add -1000, SAT=1 -> -32768.
- ReLU: acc=1, old=-10, add 3, relu=1 -> 0 written. With relu=0 -> -7 written.
- RAW: overwrite addr 9 = 50, then immediately acc addr 9 with +1 -> read returns 50, 51 written, no stall beyond the normal RMW.
- Reset mid-RMW: assert reset during ADD -> mem_cen=1 on the same edge, no write occurs, wr_count=0, in_ready=1 after release.
